// File: rtl/alu_secuenciador_entrada.sv
// ---------------------------------------------------------------------------
// alu_secuenciador_entrada
//
// Operand/operation entry stage that sits directly in front of the
// generalized ALU. Each press of the debounced button captures the next item
// from the board switches: first operand A, then operand B, then the opcode.
// The captured values are held stable on the ALU inputs. One cycle later the
// ALU's combinational result and overflow are registered for the VGA stage.
//
// Build option:
//   ACUMULADOR_EN  when defined, a press while a result is shown loads that
//                  result into operand A and jumps straight to loading B.
//                  This allows chained operations. When undefined, a press
//                  while a result is shown returns to loading A.
//
// Parameters:
//   N_BITS          operand/result width (must match the ALU's n_bits)
//
// Ports:
//   clk             system clock, rising edge
//   reset_n         asynchronous active-low reset
//   dato_in         switch value, captured as A or B
//   op_in           switch opcode, captured as the operation
//   ingresar        debounced button level, synchronous to clk
//   limpiar         synchronous clear, level sensitive
//   entrada_a       registered operand A to the ALU
//   entrada_b       registered operand B to the ALU
//   operacion       registered opcode to the ALU
//   resultado_alu   ALU combinational result
//   overflow_alu    ALU combinational overflow
//   resultado_reg   latched result for the display
//   overflow_reg    latched overflow for the display
//   valido          high while resultado_reg belongs to the current operands
//   nuevo_resultado one-cycle pulse when resultado_reg has just been updated
//   op_invalida     one-cycle pulse when an unsupported opcode is rejected
//   estado          current FSM state encoding (debug/display)
//
// Output handshake: the display stage has no back-pressure. valido is a
// level that says resultado_reg/overflow_reg are meaningful. nuevo_resultado
// rises in the same cycle that valido first rises for a new result, and it
// lasts exactly one cycle. Both signals change only on clk edges, or on
// reset.
// ---------------------------------------------------------------------------
module alu_secuenciador_entrada #(
    parameter int N_BITS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_BITS-1:0] dato_in,
    input  logic [2:0]        op_in,
    input  logic              ingresar,
    input  logic              limpiar,
    output logic [N_BITS-1:0] entrada_a,
    output logic [N_BITS-1:0] entrada_b,
    output logic [2:0]        operacion,
    input  logic [N_BITS-1:0] resultado_alu,
    input  logic              overflow_alu,
    output logic [N_BITS-1:0] resultado_reg,
    output logic              overflow_reg,
    output logic              valido,
    output logic              nuevo_resultado,
    output logic              op_invalida,
    output logic [2:0]        estado
);

    typedef enum logic [2:0] {
        CARGA_A  = 3'd0,
        CARGA_B  = 3'd1,
        CARGA_OP = 3'd2,
        CALCULO  = 3'd3,
        MOSTRAR  = 3'd4
    } estado_t;

    estado_t estado_q, estado_sig;

    logic              ingresar_prev;
    logic              evento;

    logic [N_BITS-1:0] entrada_a_sig;
    logic [N_BITS-1:0] entrada_b_sig;
    logic [2:0]        operacion_sig;
    logic [N_BITS-1:0] resultado_sig;
    logic              overflow_sig;
    logic              valido_sig;
    logic              nuevo_sig;
    logic              invalida_sig;

    // Only the rising edge of the button level counts. Holding the button
    // down therefore produces a single capture.
    assign evento = ingresar & ~ingresar_prev;

    assign estado = estado_q;

    // Opcodes that the downstream ALU implements.
    function automatic logic op_soportada(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_soportada = 1'b1;
            default:                                op_soportada = 1'b0;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Next-state and next-register logic. Every register holds by default.
    // The two pulse outputs default to low.
    // -----------------------------------------------------------------------
    always_comb begin
        estado_sig    = estado_q;
        entrada_a_sig = entrada_a;
        entrada_b_sig = entrada_b;
        operacion_sig = operacion;
        resultado_sig = resultado_reg;
        overflow_sig  = overflow_reg;
        valido_sig    = valido;
        nuevo_sig     = 1'b0;
        invalida_sig  = 1'b0;

        if (limpiar) begin
            // Clear beats any press on the same edge, in every state.
            estado_sig    = CARGA_A;
            entrada_a_sig = '0;
            entrada_b_sig = '0;
            operacion_sig = '0;
            resultado_sig = '0;
            overflow_sig  = 1'b0;
            valido_sig    = 1'b0;
        end else begin
            case (estado_q)
                CARGA_A: begin
                    if (evento) begin
                        entrada_a_sig = dato_in;
                        valido_sig    = 1'b0;
                        estado_sig    = CARGA_B;
                    end
                end
                CARGA_B: begin
                    if (evento) begin
                        entrada_b_sig = dato_in;
                        estado_sig    = CARGA_OP;
                    end
                end
                CARGA_OP: begin
                    if (evento) begin
                        if (op_soportada(op_in)) begin
                            operacion_sig = op_in;
                            estado_sig    = CALCULO;
                        end else begin
                            invalida_sig  = 1'b1;
                        end
                    end
                end
                CALCULO: begin
                    // The operands have been stable on the ALU inputs for a
                    // full cycle, so its combinational output has settled.
                    // Presses here are ignored.
                    resultado_sig = resultado_alu;
                    overflow_sig  = overflow_alu;
                    valido_sig    = 1'b1;
                    nuevo_sig     = 1'b1;
                    estado_sig    = MOSTRAR;
                end
                MOSTRAR: begin
                    if (evento) begin
                        valido_sig = 1'b0;
`ifdef ACUMULADOR_EN
                        entrada_a_sig = resultado_reg;
                        estado_sig    = CARGA_B;
`else
                        estado_sig    = CARGA_A;
`endif
                    end
                end
                default: begin
                    estado_sig = CARGA_A;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State and data registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q        <= CARGA_A;
            ingresar_prev   <= 1'b0;
            entrada_a       <= '0;
            entrada_b       <= '0;
            operacion       <= '0;
            resultado_reg   <= '0;
            overflow_reg    <= 1'b0;
            valido          <= 1'b0;
            nuevo_resultado <= 1'b0;
            op_invalida     <= 1'b0;
        end else begin
            estado_q        <= estado_sig;
            ingresar_prev   <= ingresar;
            entrada_a       <= entrada_a_sig;
            entrada_b       <= entrada_b_sig;
            operacion       <= operacion_sig;
            resultado_reg   <= resultado_sig;
            overflow_reg    <= overflow_sig;
            valido          <= valido_sig;
            nuevo_resultado <= nuevo_sig;
            op_invalida     <= invalida_sig;
        end
    end

endmodule

// File: tb/tb_alu_secuenciador_entrada.sv
// ---------------------------------------------------------------------------
// tb_alu_secuenciador_entrada
//
// Bench for the ALU entry sequencer. A small behavioural ALU closes the loop
// on the operand outputs. Each accepted calculation pushes its expected
// {overflow, result} into exp_q. A monitor pops one entry whenever the DUT
// raises nuevo_resultado and compares it with the latched result.
// ---------------------------------------------------------------------------
module tb_alu_secuenciador_entrada;

    localparam int N_BITS = 8;
    localparam int W      = N_BITS + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [N_BITS-1:0] dato_in;
    logic [2:0]        op_in;
    logic              ingresar;
    logic              limpiar;
    logic [N_BITS-1:0] entrada_a;
    logic [N_BITS-1:0] entrada_b;
    logic [2:0]        operacion;
    logic [N_BITS-1:0] resultado_alu;
    logic              overflow_alu;
    logic [N_BITS-1:0] resultado_reg;
    logic              overflow_reg;
    logic              valido;
    logic              nuevo_resultado;
    logic              op_invalida;
    logic [2:0]        estado;

    alu_secuenciador_entrada #(.N_BITS(N_BITS)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .dato_in         (dato_in),
        .op_in           (op_in),
        .ingresar        (ingresar),
        .limpiar         (limpiar),
        .entrada_a       (entrada_a),
        .entrada_b       (entrada_b),
        .operacion       (operacion),
        .resultado_alu   (resultado_alu),
        .overflow_alu    (overflow_alu),
        .resultado_reg   (resultado_reg),
        .overflow_reg    (overflow_reg),
        .valido          (valido),
        .nuevo_resultado (nuevo_resultado),
        .op_invalida     (op_invalida),
        .estado          (estado)
    );

    // ---------------- behavioural ALU ----------------
    // 000 add, 001 and, 010 or, 100 sub, 101 xor.
    // Overflow is the carry on add and the borrow on sub.
    function automatic logic [W-1:0] alu_f(input logic [2:0] op,
                                           input logic [N_BITS-1:0] a,
                                           input logic [N_BITS-1:0] b);
        logic [W-1:0] r;
        case (op)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {1'b0, a & b};
            3'b010:  r = {1'b0, a | b};
            3'b100:  r = {(a < b), a - b};
            3'b101:  r = {1'b0, a ^ b};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign {overflow_alu, resultado_alu} = alu_f(operacion, entrada_a, entrada_b);

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (reset_n && nuevo_resultado) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("sb_resultado", {24'd0, resultado_reg}, {24'd0, e[N_BITS-1:0]});
                check("sb_overflow", {31'd0, overflow_reg}, {31'd0, e[N_BITS]});
                check("sb_valido", {31'd0, valido}, 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [N_BITS-1:0] d, input logic [2:0] o);
        dato_in  = d;
        op_in    = o;
        ingresar = 1'b1;
        step();
        ingresar = 1'b0;
        step();
    endtask

    // Full A/B/op sequence from CARGA_A with a supported opcode.
    task automatic run_calc(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b,
                            input logic [2:0] o);
        press(a, 3'b000);
        press(b, 3'b000);
        exp_q.push_back(alu_f(o, a, b));
        press(8'h00, o);
        step();
    endtask

    task automatic clear();
        limpiar = 1'b1;
        step();
        limpiar = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_estado"}, {29'd0, estado}, 32'd0);
        check({tag, "_a"}, {24'd0, entrada_a}, 32'd0);
        check({tag, "_b"}, {24'd0, entrada_b}, 32'd0);
        check({tag, "_op"}, {29'd0, operacion}, 32'd0);
        check({tag, "_res"}, {24'd0, resultado_reg}, 32'd0);
        check({tag, "_ovf"}, {31'd0, overflow_reg}, 32'd0);
        check({tag, "_valido"}, {31'd0, valido}, 32'd0);
        check({tag, "_nuevo"}, {31'd0, nuevo_resultado}, 32'd0);
        check({tag, "_inval"}, {31'd0, op_invalida}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n  = 1'b0;
        dato_in  = '0;
        op_in    = '0;
        ingresar = 1'b0;
        limpiar  = 1'b0;
        #12;
        check_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Add 5+3 with explicit pulse timing around the op press.
        press(8'd5, 3'b000);
        press(8'd3, 3'b000);
        check("carga_b_estado", {29'd0, estado}, 32'd2);
        check("carga_b_b", {24'd0, entrada_b}, 32'd3);
        exp_q.push_back(alu_f(3'b000, 8'd5, 8'd3));
        op_in    = 3'b000;
        ingresar = 1'b1;
        step();                                   // edge T
        check("add_calc_estado", {29'd0, estado}, 32'd3);
        check("add_nuevo_T", {31'd0, nuevo_resultado}, 32'd0);
        check("add_valido_T", {31'd0, valido}, 32'd0);
        ingresar = 1'b0;
        step();                                   // edge T+1
        check("add_nuevo_T1", {31'd0, nuevo_resultado}, 32'd1);
        check("add_res", {24'd0, resultado_reg}, 32'd8);
        check("add_ovf", {31'd0, overflow_reg}, 32'd0);
        check("add_valido", {31'd0, valido}, 32'd1);
        check("add_mostrar", {29'd0, estado}, 32'd4);
        step();                                   // edge T+2
        check("add_nuevo_T2", {31'd0, nuevo_resultado}, 32'd0);
        check("add_valido_hold", {31'd0, valido}, 32'd1);

        // Asynchronous reset while showing a result.
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #3 reset_n = 1'b1;
        step();

        // Button held for 20 cycles captures A exactly once.
        dato_in  = 8'h77;
        ingresar = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            dato_in = 8'h10 + 8'(i);
        end
        ingresar = 1'b0;
        step();
        check("held_estado", {29'd0, estado}, 32'd1);
        check("held_a", {24'd0, entrada_a}, 32'h77);

        // Rejected opcode, followed by a valid subtraction.
        clear();
        check("clear_estado", {29'd0, estado}, 32'd0);
        press(8'd9, 3'b000);
        press(8'd4, 3'b000);
        op_in    = 3'b111;
        ingresar = 1'b1;
        step();
        check("bad_op_pulse", {31'd0, op_invalida}, 32'd1);
        check("bad_op_estado", {29'd0, estado}, 32'd2);
        check("bad_op_oper", {29'd0, operacion}, 32'd0);
        ingresar = 1'b0;
        step();
        check("bad_op_pulse_end", {31'd0, op_invalida}, 32'd0);
        check("bad_op_estado2", {29'd0, estado}, 32'd2);
        exp_q.push_back(alu_f(3'b100, 8'd9, 8'd4));
        press(8'd0, 3'b100);
        step();
        check("sub_res", {24'd0, resultado_reg}, 32'd5);
        check("sub_oper", {29'd0, operacion}, 32'd4);

        // Clear has priority over a simultaneous press in CARGA_OP.
        clear();
        press(8'd11, 3'b000);
        press(8'd22, 3'b000);
        limpiar  = 1'b1;
        ingresar = 1'b1;
        op_in    = 3'b000;
        step();
        limpiar  = 1'b0;
        ingresar = 1'b0;
        check("clr_prio_estado", {29'd0, estado}, 32'd0);
        check("clr_prio_a", {24'd0, entrada_a}, 32'd0);
        check("clr_prio_b", {24'd0, entrada_b}, 32'd0);
        step();

        // Chained operation after 5+3.
        run_calc(8'd5, 8'd3, 3'b000);
        check("chain_base", {24'd0, resultado_reg}, 32'd8);
        press(8'h55, 3'b000);
        check("chain_valido", {31'd0, valido}, 32'd0);
`ifdef ACUMULADOR_EN
        check("chain_estado", {29'd0, estado}, 32'd1);
        check("chain_a", {24'd0, entrada_a}, 32'd8);
        press(8'd2, 3'b000);
        exp_q.push_back(alu_f(3'b000, 8'd8, 8'd2));
        press(8'd0, 3'b000);
        step();
        check("chain_a_hold", {24'd0, entrada_a}, 32'd8);
`else
        check("chain_estado", {29'd0, estado}, 32'd0);
        check("chain_a_keep", {24'd0, entrada_a}, 32'd5);
        check("chain_b_keep", {24'd0, entrada_b}, 32'd3);
        run_calc(8'd8, 8'd2, 3'b000);
`endif
        check("chain_res", {24'd0, resultado_reg}, 32'd10);

        // Overflow cases.
        clear();
        run_calc(8'd200, 8'd100, 3'b000);
        check("add_ovf_flag", {31'd0, overflow_reg}, 32'd1);
        clear();
        run_calc(8'd3, 8'd5, 3'b100);
        check("sub_borrow_res", {24'd0, resultado_reg}, 32'hFE);

        // Random operations, including unsupported opcodes.
        for (int i = 0; i < 30; i++) begin
            logic [N_BITS-1:0] a, b;
            logic [2:0]        o;
            a = N_BITS'($urandom_range(0, 255));
            b = N_BITS'($urandom_range(0, 255));
            o = 3'($urandom_range(0, 7));
            clear();
            if (o == 3'b011 || o == 3'b110 || o == 3'b111) begin
                press(a, 3'b000);
                press(b, 3'b000);
                op_in    = o;
                ingresar = 1'b1;
                step();
                ingresar = 1'b0;
                check("rnd_inval", {31'd0, op_invalida}, 32'd1);
                check("rnd_inval_estado", {29'd0, estado}, 32'd2);
                step();
            end else begin
                run_calc(a, b, o);
                check("rnd_oper", {29'd0, operacion}, {29'd0, o});
            end
        end

        step();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
